rename_stage: RTL and testbench

RENAME_STAGE -- requirements
Module: rename_stage

---
 rtl/rename_stage_pkg.sv | 12 +
 rtl/rename_stage_if.sv | 62 ++++++
 rtl/rename_stage_rat_checkpoints.sv | 27 ++
 rtl/rename_stage.sv | 156 +++++++++++++++
 tb/tb_rename_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_stage_pkg.sv
// Shared rename constants and types: physical register pool size and branch
// speculation depth used by the rename stage, its interface and checkpoints.
package rename_stage_pkg;

    localparam int unsigned NUM_PREGS              = 64;
    localparam int unsigned MAX_PREDICT_DEPTH      = 4;
    localparam int unsigned MAX_PREDICT_DEPTH_BITS = 3;

    typedef logic [$clog2(NUM_PREGS)-1:0]      preg_t;
    typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_t;

endpackage

// File: rtl/rename_stage_if.sv
// Bundle of the two-slot rename group, freelist, recovery and output signals.
// slave is the rename stage's view; master is the surrounding pipeline's view.
interface rename_stage_if
    import rename_stage_pkg::*;
#(
    parameter int unsigned NUM_AREGS              = 16,
    parameter int unsigned NUM_PREGS              = rename_stage_pkg::NUM_PREGS,
    parameter int unsigned MAX_PREDICT_DEPTH_BITS = rename_stage_pkg::MAX_PREDICT_DEPTH_BITS
);
    localparam int unsigned AREG_W = $clog2(NUM_AREGS);
    localparam int unsigned PREG_W = $clog2(NUM_PREGS);
    localparam int unsigned TAG_W  = MAX_PREDICT_DEPTH_BITS;

    logic              in_valid_0, in_valid_1;
    logic              in_dst_we_0, in_dst_we_1;
    logic [AREG_W-1:0] in_dst_0, in_srca_0, in_srcb_0;
    logic [AREG_W-1:0] in_dst_1, in_srca_1, in_srcb_1;
    logic              in_is_branch_0, in_is_branch_1;
    logic              in_accept_0, in_accept_1;

    logic [PREG_W-1:0] preg1, preg2;
    logic [PREG_W:0]   num_free;
    logic [1:0]        alloc_num;
    logic [TAG_W-1:0]  branch_tag_1, branch_tag_2;

    logic              branch_shootdown;
    logic [TAG_W-1:0]  shootdown_branch_tag;
    logic              branch_pop;

    logic              out_valid_0, out_valid_1;
    logic              out_ready;
    logic [PREG_W-1:0] out_psrca_0, out_psrcb_0, out_pdst_0, out_old_pdst_0;
    logic [PREG_W-1:0] out_psrca_1, out_psrcb_1, out_pdst_1, out_old_pdst_1;
    logic [TAG_W-1:0]  out_tag_0, out_tag_1;

    modport slave (
        input  in_valid_0, in_valid_1, in_dst_we_0, in_dst_we_1,
               in_dst_0, in_srca_0, in_srcb_0, in_dst_1, in_srca_1, in_srcb_1,
               in_is_branch_0, in_is_branch_1,
               preg1, preg2, num_free,
               branch_shootdown, shootdown_branch_tag, branch_pop, out_ready,
        output in_accept_0, in_accept_1, alloc_num, branch_tag_1, branch_tag_2,
               out_valid_0, out_valid_1,
               out_psrca_0, out_psrcb_0, out_pdst_0, out_old_pdst_0,
               out_psrca_1, out_psrcb_1, out_pdst_1, out_old_pdst_1,
               out_tag_0, out_tag_1
    );

    modport master (
        output in_valid_0, in_valid_1, in_dst_we_0, in_dst_we_1,
               in_dst_0, in_srca_0, in_srcb_0, in_dst_1, in_srca_1, in_srcb_1,
               in_is_branch_0, in_is_branch_1,
               preg1, preg2, num_free,
               branch_shootdown, shootdown_branch_tag, branch_pop, out_ready,
        input  in_accept_0, in_accept_1, alloc_num, branch_tag_1, branch_tag_2,
               out_valid_0, out_valid_1,
               out_psrca_0, out_psrcb_0, out_pdst_0, out_old_pdst_0,
               out_psrca_1, out_psrcb_1, out_pdst_1, out_old_pdst_1,
               out_tag_0, out_tag_1
    );

endinterface

// File: rtl/rename_stage_rat_checkpoints.sv
// Branch checkpoint store: one full map-table copy per speculation level,
// one synchronous write port and one combinational read port.
module rat_checkpoints
    import rename_stage_pkg::*;
#(
    parameter int unsigned NUM_AREGS         = 16,
    parameter int unsigned PREG_W            = $clog2(rename_stage_pkg::NUM_PREGS),
    parameter int unsigned MAX_PREDICT_DEPTH = rename_stage_pkg::MAX_PREDICT_DEPTH,
    parameter int unsigned AW                = 2
) (
    input  logic                              clk,
    input  logic                              i_we,
    input  logic [AW-1:0]                     i_waddr,
    input  logic [NUM_AREGS-1:0][PREG_W-1:0]  i_wdata,
    input  logic [AW-1:0]                     i_raddr,
    output logic [NUM_AREGS-1:0][PREG_W-1:0]  o_rdata_c
);
    logic [NUM_AREGS-1:0][PREG_W-1:0] r_mem [MAX_PREDICT_DEPTH];

    // Contents are only meaningful once written by a branch, so no reset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/rename_stage.sv
// Two-wide register rename: RAT lookup with intra-group bypass, preg
// allocation from the freelist, branch checkpointing and shootdown recovery.
module rename_stage
    import rename_stage_pkg::*;
#(
    parameter int unsigned NUM_AREGS              = 16,
    parameter int unsigned NUM_PREGS              = rename_stage_pkg::NUM_PREGS,
    parameter int unsigned MAX_PREDICT_DEPTH      = rename_stage_pkg::MAX_PREDICT_DEPTH,
    parameter int unsigned MAX_PREDICT_DEPTH_BITS = rename_stage_pkg::MAX_PREDICT_DEPTH_BITS
) (
    input  logic          clk,
    input  logic          reset_n,
    rename_stage_if.slave bus
);
    localparam int unsigned PREG_W = $clog2(NUM_PREGS);
    localparam int unsigned TAG_W  = MAX_PREDICT_DEPTH_BITS;
    localparam int unsigned CNT_W  = PREG_W + 1;
    localparam int unsigned CP_AW  = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1;
    localparam logic [TAG_W-1:0] MAX_D = TAG_W'(MAX_PREDICT_DEPTH);

    typedef logic [NUM_AREGS-1:0][PREG_W-1:0] rat_t;

    rat_t             r_rat;
    logic [TAG_W-1:0] r_depth;

    logic              r_out_valid_0, r_out_valid_1;
    logic [PREG_W-1:0] r_psrca_0, r_psrcb_0, r_pdst_0, r_old_pdst_0;
    logic [PREG_W-1:0] r_psrca_1, r_psrcb_1, r_pdst_1, r_old_pdst_1;
    logic [TAG_W-1:0]  r_tag_0, r_tag_1;

    logic              w_shoot, w_pop, w_can_load;
    logic [TAG_W-1:0]  w_base, w_tag0, w_tag1, w_shoot_tag_m1, w_depth_nxt;
    logic [CNT_W-1:0]  w_need0, w_need01;
    logic              w_acc0, w_acc1, w_alloc0, w_alloc1, w_br_acc;
    logic [PREG_W-1:0] w_pd0, w_pd1, w_psrca_1, w_psrcb_1, w_old_pdst_1;
    rat_t              w_rat_mid, w_rat_nxt, w_cp_wdata, w_cp_rdata;
    logic              w_cp_we;

    assign w_shoot        = bus.branch_shootdown;
    assign w_shoot_tag_m1 = bus.shootdown_branch_tag - TAG_W'(1);
    assign w_pop          = bus.branch_pop && !w_shoot && (r_depth != '0);
    // A same-cycle pop frees the youngest level before any new branch claims one.
    assign w_base         = r_depth - TAG_W'(w_pop);
    assign w_can_load     = !(r_out_valid_0 || r_out_valid_1) || bus.out_ready;

    assign w_need0  = CNT_W'(bus.in_dst_we_0);
    assign w_need01 = w_need0 + CNT_W'(bus.in_dst_we_1);
    assign w_tag0   = w_base;
    assign w_tag1   = w_base + TAG_W'(bus.in_is_branch_0);

    assign w_acc0 = reset_n && !w_shoot && bus.in_valid_0 && w_can_load
                 && (bus.num_free >= w_need0)
                 && (!bus.in_is_branch_0 || (w_tag0 < MAX_D));
    assign w_acc1 = w_acc0 && bus.in_valid_1
                 && (bus.num_free >= w_need01)
                 && !(bus.in_is_branch_0 && bus.in_is_branch_1)
                 && (!bus.in_is_branch_1 || (w_tag1 < MAX_D));

    assign w_alloc0 = w_acc0 && bus.in_dst_we_0;
    assign w_alloc1 = w_acc1 && bus.in_dst_we_1;
    assign w_pd0    = bus.preg1;
    assign w_pd1    = w_alloc0 ? bus.preg2 : bus.preg1;

    assign bus.in_accept_0  = w_acc0;
    assign bus.in_accept_1  = w_acc1;
    assign bus.alloc_num    = 2'(w_alloc0) + 2'(w_alloc1);
    assign bus.branch_tag_1 = w_alloc0 ? w_tag0 : (w_alloc1 ? w_tag1 : '0);
    assign bus.branch_tag_2 = (w_alloc0 && w_alloc1) ? w_tag1 : '0;

    // Slot 1 sees slot 0's fresh mapping for sources and for its old pdst.
    assign w_psrca_1    = (bus.in_dst_we_0 && (bus.in_srca_1 == bus.in_dst_0)) ? w_pd0 : r_rat[bus.in_srca_1];
    assign w_psrcb_1    = (bus.in_dst_we_0 && (bus.in_srcb_1 == bus.in_dst_0)) ? w_pd0 : r_rat[bus.in_srcb_1];
    assign w_old_pdst_1 = (bus.in_dst_we_0 && (bus.in_dst_1 == bus.in_dst_0)) ? w_pd0 : r_rat[bus.in_dst_1];

    always_comb begin
        w_rat_mid = r_rat;
        if (w_alloc0) w_rat_mid[bus.in_dst_0] = w_pd0;
        w_rat_nxt = w_rat_mid;
        if (w_alloc1) w_rat_nxt[bus.in_dst_1] = w_pd1;
    end

    // A slot-1 branch snapshots the table after slot 0's update.
    assign w_br_acc    = (w_acc0 && bus.in_is_branch_0) || (w_acc1 && bus.in_is_branch_1);
    assign w_cp_we     = w_br_acc;
    assign w_cp_wdata  = (w_acc1 && bus.in_is_branch_1) ? w_rat_mid : r_rat;
    assign w_depth_nxt = w_base + TAG_W'(w_br_acc);

    rat_checkpoints #(
        .NUM_AREGS         (NUM_AREGS),
        .PREG_W            (PREG_W),
        .MAX_PREDICT_DEPTH (MAX_PREDICT_DEPTH),
        .AW                (CP_AW)
    ) u_ckpt (
        .clk       (clk),
        .i_we      (w_cp_we),
        .i_waddr   (CP_AW'(w_base)),
        .i_wdata   (w_cp_wdata),
        .i_raddr   (CP_AW'(w_shoot_tag_m1)),
        .o_rdata_c (w_cp_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_AREGS; i++) r_rat[i] <= PREG_W'(i);
            r_depth       <= '0;
            r_out_valid_0 <= 1'b0;
            r_out_valid_1 <= 1'b0;
            r_psrca_0     <= '0;
            r_psrcb_0     <= '0;
            r_pdst_0      <= '0;
            r_old_pdst_0  <= '0;
            r_tag_0       <= '0;
            r_psrca_1     <= '0;
            r_psrcb_1     <= '0;
            r_pdst_1      <= '0;
            r_old_pdst_1  <= '0;
            r_tag_1       <= '0;
        end else if (w_shoot) begin
            r_rat         <= w_cp_rdata;
            r_depth       <= w_shoot_tag_m1;
            r_out_valid_0 <= 1'b0;
            r_out_valid_1 <= 1'b0;
        end else begin
            r_rat   <= w_rat_nxt;
            r_depth <= w_depth_nxt;
            if (w_can_load) begin
                r_out_valid_0 <= w_acc0;
                r_out_valid_1 <= w_acc1;
                r_psrca_0     <= r_rat[bus.in_srca_0];
                r_psrcb_0     <= r_rat[bus.in_srcb_0];
                r_pdst_0      <= w_alloc0 ? w_pd0 : '0;
                r_old_pdst_0  <= r_rat[bus.in_dst_0];
                r_tag_0       <= w_tag0;
                r_psrca_1     <= w_psrca_1;
                r_psrcb_1     <= w_psrcb_1;
                r_pdst_1      <= w_alloc1 ? w_pd1 : '0;
                r_old_pdst_1  <= w_old_pdst_1;
                r_tag_1       <= w_tag1;
            end
        end
    end

    assign bus.out_valid_0    = r_out_valid_0;
    assign bus.out_valid_1    = r_out_valid_1;
    assign bus.out_psrca_0    = r_psrca_0;
    assign bus.out_psrcb_0    = r_psrcb_0;
    assign bus.out_pdst_0     = r_pdst_0;
    assign bus.out_old_pdst_0 = r_old_pdst_0;
    assign bus.out_tag_0      = r_tag_0;
    assign bus.out_psrca_1    = r_psrca_1;
    assign bus.out_psrcb_1    = r_psrcb_1;
    assign bus.out_pdst_1     = r_pdst_1;
    assign bus.out_old_pdst_1 = r_old_pdst_1;
    assign bus.out_tag_1      = r_tag_1;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: renaming, bypass, freelist and depth
// limits, checkpoint recovery, output stall and asynchronous reset.
module tb_rename_stage;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    rename_stage_if bus_if ();

    rename_stage u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set0(input int v, input int we, input int d, input int a, input int b, input int br);
        bus_if.in_valid_0     = 1'(v);
        bus_if.in_dst_we_0    = 1'(we);
        bus_if.in_dst_0       = 4'(d);
        bus_if.in_srca_0      = 4'(a);
        bus_if.in_srcb_0      = 4'(b);
        bus_if.in_is_branch_0 = 1'(br);
    endtask

    task automatic set1(input int v, input int we, input int d, input int a, input int b, input int br);
        bus_if.in_valid_1     = 1'(v);
        bus_if.in_dst_we_1    = 1'(we);
        bus_if.in_dst_1       = 4'(d);
        bus_if.in_srca_1      = 4'(a);
        bus_if.in_srcb_1      = 4'(b);
        bus_if.in_is_branch_1 = 1'(br);
    endtask

    task automatic setfl(input int p1, input int p2, input int nf);
        bus_if.preg1    = 6'(p1);
        bus_if.preg2    = 6'(p2);
        bus_if.num_free = 7'(nf);
    endtask

    task automatic clr();
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        setfl(0, 0, 64);
        bus_if.branch_shootdown     = 1'b0;
        bus_if.shootdown_branch_tag = 3'd0;
        bus_if.branch_pop           = 1'b0;
        bus_if.out_ready            = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clr();
        set0(1, 1, 1, 0, 0, 0);
        #2;
        check("rst_valid0", 32'(bus_if.out_valid_0), 0);
        check("rst_accept0", 32'(bus_if.in_accept_0), 0);
        check("rst_alloc", 32'(bus_if.alloc_num), 0);
        tick();
        reset_n = 1'b1;
        clr();

        // two slots, slot 1 reads slot 0's destination
        set0(1, 1, 1, 0, 0, 0);
        set1(1, 1, 2, 1, 2, 0);
        setfl(20, 21, 10);
        #1;
        check("s1_acc0", 32'(bus_if.in_accept_0), 1);
        check("s1_acc1", 32'(bus_if.in_accept_1), 1);
        check("s1_alloc", 32'(bus_if.alloc_num), 2);
        tick();
        check("s1_valid1", 32'(bus_if.out_valid_1), 1);
        check("s1_pdst0", 32'(bus_if.out_pdst_0), 20);
        check("s1_pdst1", 32'(bus_if.out_pdst_1), 21);
        check("s1_psrca1", 32'(bus_if.out_psrca_1), 20);
        check("s1_psrcb1", 32'(bus_if.out_psrcb_1), 2);
        check("s1_old0", 32'(bus_if.out_old_pdst_0), 1);
        check("s1_old1", 32'(bus_if.out_old_pdst_1), 2);

        // both slots write r5: slot 1 old pdst and source bypass from slot 0
        set0(1, 1, 5, 1, 0, 0);
        set1(1, 1, 5, 5, 2, 0);
        setfl(22, 23, 10);
        tick();
        check("same_psrca0", 32'(bus_if.out_psrca_0), 20);
        check("same_psrca1", 32'(bus_if.out_psrca_1), 22);
        check("same_psrcb1", 32'(bus_if.out_psrcb_1), 21);
        check("same_old1", 32'(bus_if.out_old_pdst_1), 22);
        check("same_pdst1", 32'(bus_if.out_pdst_1), 23);

        // only slot 1 allocates: it takes preg1; r5 must now map to 23
        set0(1, 0, 0, 5, 1, 0);
        set1(1, 1, 6, 2, 0, 0);
        setfl(24, 25, 10);
        #1;
        check("s1only_alloc", 32'(bus_if.alloc_num), 1);
        tick();
        check("rat_r5", 32'(bus_if.out_psrca_0), 23);
        check("rat_r1", 32'(bus_if.out_psrcb_0), 20);
        check("s1only_pdst1", 32'(bus_if.out_pdst_1), 24);

        // one free preg, both slots want one
        set0(1, 1, 7, 0, 0, 0);
        set1(1, 1, 8, 0, 0, 0);
        setfl(26, 27, 1);
        #1;
        check("nf_acc0", 32'(bus_if.in_accept_0), 1);
        check("nf_acc1", 32'(bus_if.in_accept_1), 0);
        check("nf_alloc", 32'(bus_if.alloc_num), 1);
        tick();
        check("nf_valid1", 32'(bus_if.out_valid_1), 0);
        check("nf_pdst0", 32'(bus_if.out_pdst_0), 26);

        // r3 -> 30, branch, r3 -> 40, shootdown tag 1
        clr();
        set0(1, 1, 3, 0, 0, 0);
        setfl(30, 31, 10);
        tick();
        check("r3_old", 32'(bus_if.out_old_pdst_0), 3);
        set0(1, 0, 0, 0, 0, 1);
        set1(1, 1, 3, 3, 0, 0);
        setfl(40, 41, 10);
        #1;
        check("br_btag1", 32'(bus_if.branch_tag_1), 1);
        tick();
        check("br_tag0", 32'(bus_if.out_tag_0), 0);
        check("br_tag1", 32'(bus_if.out_tag_1), 1);
        check("br_pdst1", 32'(bus_if.out_pdst_1), 40);
        check("br_old1", 32'(bus_if.out_old_pdst_1), 30);
        clr();
        set0(1, 0, 0, 3, 0, 0);
        tick();
        check("spec_r3", 32'(bus_if.out_psrca_0), 40);
        check("spec_tag", 32'(bus_if.out_tag_0), 1);
        set0(1, 1, 4, 0, 0, 0);
        setfl(42, 43, 10);
        bus_if.branch_shootdown     = 1'b1;
        bus_if.shootdown_branch_tag = 3'd1;
        #1;
        check("sd_acc0", 32'(bus_if.in_accept_0), 0);
        check("sd_alloc", 32'(bus_if.alloc_num), 0);
        tick();
        check("sd_valid0", 32'(bus_if.out_valid_0), 0);
        check("sd_valid1", 32'(bus_if.out_valid_1), 0);
        clr();
        set0(1, 0, 0, 3, 0, 0);
        tick();
        check("sd_r3", 32'(bus_if.out_psrca_0), 30);
        check("sd_depth", 32'(bus_if.out_tag_0), 0);

        // fill speculation depth to the limit
        clr();
        set0(1, 0, 0, 0, 0, 1);
        set1(1, 0, 0, 0, 0, 1);
        #1;
        check("2br_acc1", 32'(bus_if.in_accept_1), 0);
        tick();
        check("2br_tag0", 32'(bus_if.out_tag_0), 0);
        set1(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 3; i++) begin
            tick();
            check("depth_tag", 32'(bus_if.out_tag_0), i);
        end
        set0(1, 1, 9, 0, 0, 0);
        set1(1, 0, 0, 0, 0, 1);
        setfl(50, 51, 10);
        #1;
        check("d3_acc1", 32'(bus_if.in_accept_1), 1);
        check("d3_btag1", 32'(bus_if.branch_tag_1), 3);
        tick();
        check("d3_tag1", 32'(bus_if.out_tag_1), 3);
        set0(1, 0, 0, 0, 0, 0);
        set1(1, 0, 0, 0, 0, 1);
        #1;
        check("d4_acc0", 32'(bus_if.in_accept_0), 1);
        check("d4_acc1", 32'(bus_if.in_accept_1), 0);
        tick();
        check("d4_tag0", 32'(bus_if.out_tag_0), 4);
        set0(1, 1, 10, 0, 0, 1);
        set1(1, 1, 11, 0, 0, 0);
        #1;
        check("full_acc0", 32'(bus_if.in_accept_0), 0);
        check("full_acc1", 32'(bus_if.in_accept_1), 0);
        check("full_alloc", 32'(bus_if.alloc_num), 0);
        tick();
        check("full_valid0", 32'(bus_if.out_valid_0), 0);

        // pop one level, then squash back to the first checkpoint
        clr();
        bus_if.branch_pop = 1'b1;
        tick();
        clr();
        set0(1, 0, 0, 9, 0, 0);
        tick();
        check("pop_tag", 32'(bus_if.out_tag_0), 3);
        check("pop_r9", 32'(bus_if.out_psrca_0), 50);
        clr();
        bus_if.branch_shootdown     = 1'b1;
        bus_if.shootdown_branch_tag = 3'd1;
        tick();
        clr();
        set0(1, 0, 0, 9, 3, 0);
        tick();
        check("sd2_r9", 32'(bus_if.out_psrca_0), 9);
        check("sd2_r3", 32'(bus_if.out_psrcb_0), 30);
        check("sd2_tag", 32'(bus_if.out_tag_0), 0);

        // output register stall
        clr();
        set0(1, 1, 10, 0, 0, 0);
        setfl(60, 61, 10);
        tick();
        check("st_pdst", 32'(bus_if.out_pdst_0), 60);
        bus_if.out_ready = 1'b0;
        set0(1, 1, 11, 0, 0, 0);
        setfl(61, 62, 10);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_acc0", 32'(bus_if.in_accept_0), 0);
            check("st_alloc", 32'(bus_if.alloc_num), 0);
            tick();
            check("st_valid0", 32'(bus_if.out_valid_0), 1);
            check("st_hold", 32'(bus_if.out_pdst_0), 60);
        end
        bus_if.out_ready = 1'b1;
        #1;
        check("st_rel_acc0", 32'(bus_if.in_accept_0), 1);
        tick();
        check("st_rel_pdst", 32'(bus_if.out_pdst_0), 61);
        check("st_rel_old", 32'(bus_if.out_old_pdst_0), 11);

        // asynchronous reset mid-cycle
        set0(1, 1, 12, 0, 0, 0);
        setfl(62, 63, 10);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid0", 32'(bus_if.out_valid_0), 0);
        check("ar_acc0", 32'(bus_if.in_accept_0), 0);
        check("ar_alloc", 32'(bus_if.alloc_num), 0);
        tick();
        reset_n = 1'b1;
        clr();
        set0(1, 0, 0, 1, 5, 0);
        tick();
        check("ar_r1", 32'(bus_if.out_psrca_0), 1);
        check("ar_r5", 32'(bus_if.out_psrcb_0), 5);
        check("ar_tag", 32'(bus_if.out_tag_0), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
